// File: rtl/wb_port_arb_pkg.sv
// Shared sizes, defaults and types for the GP register-file write-port arbiter.
//   SIZE_TGT_GP  : width of a GP register index
//   SIZE_DATA    : width of a register-file data word
//   NREG_DEF     : number of GP registers
//   DEPTH_DEF    : default late-result FIFO depth
//   MAX_WAIT_DEF : default starvation threshold (cycles)
package wb_port_arb_pkg;
    localparam int SIZE_TGT_GP  = 5;
    localparam int SIZE_DATA    = 32;
    localparam int NREG_DEF     = 1 << SIZE_TGT_GP;
    localparam int DEPTH_DEF    = 4;
    localparam int MAX_WAIT_DEF = 8;

    typedef logic [SIZE_TGT_GP-1:0] gp_addr_t;
    typedef logic [SIZE_DATA-1:0]   gp_data_t;

    // One register-file write request.
    typedef struct packed {
        gp_addr_t addr;
        gp_data_t data;
    } wb_req_t;
endpackage

// File: rtl/wb_late_fifo.sv
// Late-result FIFO with per-entry valid bits and kill-by-address.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   push_i/push_req_i : enqueue a request at the tail
//   pop_i          : drop the head entry (caller guarantees non-empty)
//   kill_en_i/kill_addr_i : invalidate every entry targeting kill_addr_i
//   ready_o        : count < DEPTH (registered count only)
//   empty_o        : FIFO holds no slots
//   head_o/head_vld_o : head entry and whether it is still live
//   pend_mask_o    : onehot OR of addresses of all live entries
module wb_late_fifo
    import wb_port_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREG  = NREG_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  wb_req_t         push_req_i,
    input  logic            pop_i,
    input  logic            kill_en_i,
    input  gp_addr_t        kill_addr_i,
    output logic            ready_o,
    output logic            empty_o,
    output wb_req_t         head_o,
    output logic            head_vld_o,
    output logic [NREG-1:0] pend_mask_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    cnt_q;

    assign ready_o    = cnt_q < CW'(DEPTH);
    assign empty_o    = cnt_q == '0;
    assign head_o     = mem_q[rd_ptr_q];
    // Valid bits are only ever set on occupied slots, so this implies non-empty.
    assign head_vld_o = vld_q[rd_ptr_q];

    // Kill first, then pop, then push: a late result arriving alongside a
    // same-address pipe write is younger than nothing and is stored dead.
    always_comb begin
        vld_d = vld_q;
        if (kill_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].addr == kill_addr_i) vld_d[i] = 1'b0;
            end
        end
        if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
        if (push_i) vld_d[wr_ptr_q] = !(kill_en_i && push_req_i.addr == kill_addr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q <= vld_d;
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage needs no reset; liveness is carried by vld_q.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_req_i;
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pend_mask_o[mem_q[i].addr] = 1'b1;
        end
    end
endmodule

// File: rtl/wb_port_arb.sv
// GP register-file write-port arbiter: pipeline writeback has absolute
// priority; late results are queued and drained into idle slots.
//   iw_clk, iw_rst_n        : clock, synchronous active-low reset
//   iw_pipe_*               : pipeline writeback (never back-pressured)
//   iw_late_* / ow_late_ready : late-result handshake
//   ow_gp_write_*           : registered regfile write port
//   ow_stall_req            : registered bubble request on head starvation
//   ow_pend_mask            : registers with a live queued write
module wb_port_arb
    import wb_port_arb_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int NREG     = NREG_DEF
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst_n,
    input  logic                   iw_pipe_we,
    input  logic [SIZE_TGT_GP-1:0] iw_pipe_addr,
    input  logic [SIZE_DATA-1:0]   iw_pipe_data,
    input  logic                   iw_late_valid,
    input  logic [SIZE_TGT_GP-1:0] iw_late_addr,
    input  logic [SIZE_DATA-1:0]   iw_late_data,
    output logic                   ow_late_ready,
    output logic                   ow_gp_write_enable,
    output logic [SIZE_TGT_GP-1:0] ow_gp_write_addr,
    output logic [SIZE_DATA-1:0]   ow_gp_write_data,
    output logic                   ow_stall_req,
    output logic [NREG-1:0]        ow_pend_mask
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    wb_req_t       head;
    logic          head_vld, empty, push, pop, blocked;
    logic [WW-1:0] wait_q, wait_d;
    logic          we_q, we_d, stall_q;
    gp_addr_t      addr_q, addr_d;
    gp_data_t      data_q, data_d;

    assign push    = iw_late_valid & ow_late_ready;
    // A dead head is discarded even while the pipe owns the port.
    assign pop     = !empty && (!head_vld || !iw_pipe_we);
    assign blocked = head_vld && iw_pipe_we;

    wb_late_fifo #(.DEPTH(DEPTH), .NREG(NREG)) u_fifo (
        .clk_i       (iw_clk),
        .rst_ni      (iw_rst_n),
        .push_i      (push),
        .push_req_i  ('{addr: iw_late_addr, data: iw_late_data}),
        .pop_i       (pop),
        .kill_en_i   (iw_pipe_we),
        .kill_addr_i (iw_pipe_addr),
        .ready_o     (ow_late_ready),
        .empty_o     (empty),
        .head_o      (head),
        .head_vld_o  (head_vld),
        .pend_mask_o (ow_pend_mask)
    );

    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (iw_pipe_we) begin
            we_d   = 1'b1;
            addr_d = iw_pipe_addr;
            data_d = iw_pipe_data;
        end else if (pop && head_vld) begin
            we_d   = 1'b1;
            addr_d = head.addr;
            data_d = head.data;
        end
    end

    // Any non-blocked cycle means the head popped or the FIFO is empty.
    always_comb begin
        wait_d = '0;
        if (blocked) wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            stall_q <= wait_d >= WW'(MAX_WAIT);
        end
    end

    assign ow_gp_write_enable = we_q;
    assign ow_gp_write_addr   = addr_q;
    assign ow_gp_write_data   = data_q;
    assign ow_stall_req       = stall_q;
endmodule

// File: tb/tb_wb_port_arb.sv
module tb_wb_port_arb;
    import wb_port_arb_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
    localparam int NREG     = NREG_DEF;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   pipe_we = 1'b0;
    logic [SIZE_TGT_GP-1:0] pipe_addr = '0;
    logic [SIZE_DATA-1:0]   pipe_data = '0;
    logic                   late_valid = 1'b0;
    logic [SIZE_TGT_GP-1:0] late_addr = '0;
    logic [SIZE_DATA-1:0]   late_data = '0;
    logic                   late_ready, gp_we, stall_req;
    logic [SIZE_TGT_GP-1:0] gp_addr;
    logic [SIZE_DATA-1:0]   gp_data;
    logic [NREG-1:0]        pend_mask;

    always #5 clk = ~clk;

    wb_port_arb #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .NREG(NREG)) dut (
        .iw_clk(clk), .iw_rst_n(rst_n),
        .iw_pipe_we(pipe_we), .iw_pipe_addr(pipe_addr), .iw_pipe_data(pipe_data),
        .iw_late_valid(late_valid), .iw_late_addr(late_addr), .iw_late_data(late_data),
        .ow_late_ready(late_ready),
        .ow_gp_write_enable(gp_we), .ow_gp_write_addr(gp_addr), .ow_gp_write_data(gp_data),
        .ow_stall_req(stall_req), .ow_pend_mask(pend_mask)
    );

    // Reference model: queued late results in arrival order, each flagged live/dead.
    typedef struct {
        logic [SIZE_TGT_GP-1:0] a;
        logic [SIZE_DATA-1:0]   d;
        bit                     v;
    } ment_t;

    ment_t   mq[$];
    wb_req_t sb[$];   // expected port writes, one per cycle that writes
    int      wcnt = 0;
    bit      exp_we = 1'b0;
    bit      mon_en = 1'b0;
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level behaviour for one clock, applied to the model state.
    task automatic model_step(input bit rst, input bit pwe, input logic [4:0] pa,
                              input logic [31:0] pd, input bit lv, input logic [4:0] la,
                              input logic [31:0] ld);
        bit rdy, blk;
        if (!rst) begin
            mq.delete();
            wcnt   = 0;
            exp_we = 1'b0;
            return;
        end
        rdy    = mq.size() < DEPTH;
        blk    = 1'b0;
        exp_we = 1'b0;
        if (pwe) begin
            exp_we = 1'b1;
            sb.push_back('{addr: pa, data: pd});
        end
        if (mq.size() > 0) begin
            if (!mq[0].v) begin
                void'(mq.pop_front());
            end else if (!pwe) begin
                exp_we = 1'b1;
                sb.push_back('{addr: mq[0].a, data: mq[0].d});
                void'(mq.pop_front());
            end else begin
                blk = 1'b1;
            end
        end
        wcnt = blk ? ((wcnt < MAX_WAIT) ? wcnt + 1 : wcnt) : 0;
        if (pwe) foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 1'b0;
        if (lv && rdy) mq.push_back('{a: la, d: ld, v: !(pwe && la == pa)});
    endtask

    task automatic step(input bit rst, input bit pwe, input logic [4:0] pa,
                        input logic [31:0] pd, input bit lv, input logic [4:0] la,
                        input logic [31:0] ld);
        @(negedge clk);
        #1;
        rst_n = rst; pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
        late_valid = lv; late_addr = la; late_data = ld;
        model_step(rst, pwe, pa, pd, lv, la, ld);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares DUT outputs with the model state after each posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [NREG-1:0] em;
            wb_req_t         e;
            em = '0;
            foreach (mq[i]) if (mq[i].v) em[mq[i].a] = 1'b1;
            chk("late_ready", 64'(late_ready), 64'(mq.size() < DEPTH));
            chk("stall_req", 64'(stall_req), 64'(wcnt >= MAX_WAIT));
            chk("pend_mask", 64'(pend_mask), 64'(em));
            chk("write_enable", 64'(gp_we), 64'(exp_we));
            if (exp_we) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 64'(0), 64'(1));
                end else begin
                    e = sb.pop_front();
                    if (gp_we) begin
                        chk("write_addr", 64'(gp_addr), 64'(e.addr));
                        chk("write_data", 64'(gp_data), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        // Reset with a late result offered: nothing may be enqueued.
        step(0, 0, 0, 0, 1, 9, 32'hDEAD);
        mon_en = 1'b1;
        step(0, 0, 0, 0, 1, 9, 32'hDEAD);
        @(negedge clk);
        chk("rst_addr", 64'(gp_addr), 64'(0));
        chk("rst_data", 64'(gp_data), 64'(0));

        // Idle-port drain.
        step(1, 0, 0, 0, 1, 3, 32'h1234);
        idle(3);

        // Back-pressure: pipe busy, four pushes, starvation, then drain in order.
        for (int i = 0; i < 12; i++)
            step(1, 1, 5'd1, 32'h100 + i, i < 5, 5'(10 + i), 32'hC0 + i);
        idle(6);

        // WAW kill: queued r5 is superseded by a pipe write to r5.
        step(1, 1, 5'd1, 32'h11, 1, 5, 32'hAAAA);
        step(1, 1, 5'd5, 32'hBBBB, 0, 0, 0);
        idle(3);

        // Same-cycle same-address: late result discarded.
        step(1, 1, 5'd7, 32'h2, 1, 7, 32'h1);
        idle(3);

        // Reset mid-operation with entries queued and stall asserted.
        for (int i = 0; i < 12; i++)
            step(1, 1, 5'd2, 32'h200 + i, i < 3, 5'(20 + i), 32'hE0 + i);
        chk("stall_before_reset", 64'(stall_req), 64'(1));
        step(0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Randomised traffic over a narrow address range to force collisions.
        for (int i = 0; i < 3000; i++) begin
            bit r, pw, lv;
            r  = $urandom_range(0, 299) != 0;
            pw = $urandom_range(0, 99) < 60;
            lv = $urandom_range(0, 99) < 50;
            step(r, pw, 5'($urandom_range(0, 7)), $urandom, lv,
                 5'($urandom_range(0, 7)), $urandom);
        end
        idle(12);
        @(negedge clk);
        chk("queue_drained", 64'(mq.size()), 64'(0));
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
